// File: rtl/backend_seq_pkg.sv
// rtl/backend_seq_pkg.sv - shared state encoding and default parameters for backend_seq
package backend_seq_pkg;

  // Power-up sequencer states; LOAD is the reset state.
  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_WAIT_VCO = 3'd1,
    ST_WAIT_AMP = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_RUN      = 3'd4
  } state_e;

  localparam int DEF_N_CH   = 2;
  localparam int DEF_GAIN_W = 3;
  localparam int DEF_T_VCO  = 2;
  localparam int DEF_T_AMP  = 10;
  localparam int DEF_T_RDY  = 10;
  localparam int DEF_WIN    = 10000;
  localparam int DEF_FREQ_W = 16;

  // Largest of three delays, used to size the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with registered rising-edge pulse
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic d_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic rise_q;

  // Two metastability stages, one history stage, and the edge pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  // s3_q carries the synchronized level from the same cycle that produced rise_q,
  // so a data line through its own instance lines up with a clock line's pulse.
  assign d_o    = s3_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/backend_seq.sv
// rtl/backend_seq.sv - serial gain load, VCO/amplifier power-up sequencing and VCO frequency counter
module backend_seq
  import backend_seq_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int T_VCO  = DEF_T_VCO,
  parameter int T_AMP  = DEF_T_AMP,
  parameter int T_RDY  = DEF_T_RDY,
  parameter int WIN    = DEF_WIN,
  parameter int FREQ_W = DEF_FREQ_W
) (
  input  logic                     i_clk,
  input  logic                     i_resetbAll,
  input  logic                     i_sclk,
  input  logic                     i_sdin,
  input  logic                     i_vco_clk,
  output logic                     o_resetbvco,
  output logic [N_CH-1:0]          o_resetb,
  output logic [N_CH*GAIN_W-1:0]   o_gain,
  output logic                     o_ready,
  output logic [FREQ_W-1:0]        o_vco_count,
  output logic                     o_vco_valid
);

  localparam int TOTAL = N_CH * GAIN_W;
  localparam int BIT_W = $clog2(TOTAL + 1);
  localparam int T_MAX = max3(T_VCO, T_AMP, T_RDY);
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam int WIN_W = $clog2(WIN);

  logic sclk_rise;
  logic sdin_d;
  logic vco_rise;
  logic unused_levels;
  logic sclk_lvl;
  logic vco_lvl;
  logic sdin_rise;

  sync_edge u_sync_sclk (
    .clk_i  (i_clk),
    .rst_ni (i_resetbAll),
    .d_i    (i_sclk),
    .d_o    (sclk_lvl),
    .rise_o (sclk_rise)
  );

  sync_edge u_sync_sdin (
    .clk_i  (i_clk),
    .rst_ni (i_resetbAll),
    .d_i    (i_sdin),
    .d_o    (sdin_d),
    .rise_o (sdin_rise)
  );

  sync_edge u_sync_vco (
    .clk_i  (i_clk),
    .rst_ni (i_resetbAll),
    .d_i    (i_vco_clk),
    .d_o    (vco_lvl),
    .rise_o (vco_rise)
  );

  assign unused_levels = sclk_lvl ^ vco_lvl ^ sdin_rise;

  state_e               state_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [TMR_W-1:0]     tmr_q;
  logic [WIN_W-1:0]     win_q;
  logic [FREQ_W-1:0]    cnt_q;
  logic [FREQ_W-1:0]    cnt_next_d;
  logic [TOTAL-1:0]     gain_q;
  logic                 resetbvco_q;
  logic [N_CH-1:0]      resetb_q;
  logic                 ready_q;
  logic [FREQ_W-1:0]    vco_count_q;
  logic                 vco_valid_q;

  // Edge count including this cycle's edge, held at all-ones instead of wrapping.
  always_comb begin
    cnt_next_d = cnt_q;
    if (vco_rise && (cnt_q != {FREQ_W{1'b1}})) begin
      cnt_next_d = cnt_q + FREQ_W'(1);
    end
  end

  // Sequencer FSM with its registered outputs and the measurement window.
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state_q     <= ST_LOAD;
      bit_cnt_q   <= '0;
      tmr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      gain_q      <= '0;
      resetbvco_q <= 1'b0;
      resetb_q    <= '0;
      ready_q     <= 1'b0;
      vco_count_q <= '0;
      vco_valid_q <= 1'b0;
    end else begin
      vco_valid_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (sclk_rise) begin
            for (int i = 0; i < TOTAL; i++) begin
              if (bit_cnt_q == BIT_W'(i)) begin
                gain_q[i] <= sdin_d;
              end
            end
            if (bit_cnt_q == BIT_W'(TOTAL - 1)) begin
              state_q <= ST_WAIT_VCO;
              tmr_q   <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        ST_WAIT_VCO: begin
          if (tmr_q == TMR_W'(T_VCO - 1)) begin
            state_q     <= ST_WAIT_AMP;
            resetbvco_q <= 1'b1;
            tmr_q       <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_WAIT_AMP: begin
          if (tmr_q == TMR_W'(T_AMP - 1)) begin
            state_q  <= ST_WAIT_RDY;
            resetb_q <= '1;
            tmr_q    <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_WAIT_RDY: begin
          if (tmr_q == TMR_W'(T_RDY - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            win_q   <= '0;
            cnt_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_RUN: begin
          if (win_q == WIN_W'(WIN - 1)) begin
            vco_count_q <= cnt_next_d;
            vco_valid_q <= 1'b1;
            cnt_q       <= '0;
            win_q       <= '0;
          end else begin
            cnt_q <= cnt_next_d;
            win_q <= win_q + WIN_W'(1);
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign o_resetbvco = resetbvco_q;
  assign o_resetb    = resetb_q;
  assign o_gain      = gain_q;
  assign o_ready     = ready_q;
  assign o_vco_count = vco_count_q;
  assign o_vco_valid = vco_valid_q;

endmodule

// File: tb/tb_backend_seq.sv
// tb/tb_backend_seq.sv - directed self-checking bench for backend_seq
module tb_backend_seq;

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk  = 1'b0;
  logic sdin  = 1'b0;
  logic vco   = 1'b0;

  logic        a_resetbvco, b_resetbvco;
  logic [1:0]  a_resetb, b_resetb;
  logic [5:0]  a_gain, b_gain;
  logic        a_ready, b_ready;
  logic [15:0] a_count;
  logic [3:0]  b_count;
  logic        a_valid, b_valid;

  int vectors = 0;
  int errors  = 0;

  backend_seq #(.N_CH(2), .GAIN_W(3), .T_VCO(2), .T_AMP(10), .T_RDY(10), .WIN(100), .FREQ_W(16)) u_a (
    .i_clk(i_clk), .i_resetbAll(rst_n), .i_sclk(sclk), .i_sdin(sdin), .i_vco_clk(vco),
    .o_resetbvco(a_resetbvco), .o_resetb(a_resetb), .o_gain(a_gain), .o_ready(a_ready),
    .o_vco_count(a_count), .o_vco_valid(a_valid)
  );

  backend_seq #(.N_CH(2), .GAIN_W(3), .T_VCO(2), .T_AMP(10), .T_RDY(10), .WIN(100), .FREQ_W(4)) u_b (
    .i_clk(i_clk), .i_resetbAll(rst_n), .i_sclk(sclk), .i_sdin(sdin), .i_vco_clk(vco),
    .o_resetbvco(b_resetbvco), .o_resetb(b_resetb), .o_gain(b_gain), .o_ready(b_ready),
    .o_vco_count(b_count), .o_vco_valid(b_valid)
  );

  always #5 i_clk = ~i_clk;

  // VCO at i_clk/5, offset from the i_clk edges.
  initial begin
    #3;
    forever begin
      vco = 1'b1; #20;
      vco = 1'b0; #30;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    sdin = b; #40;
    sclk = 1'b1; #50;
    sclk = 1'b0; #40;
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(5);
    vectors++; if ({a_resetbvco, a_resetb, a_ready, a_valid} !== 5'b0) begin errors++; $display("FAIL rst_a_ctrl: got %b expected 00000", {a_resetbvco, a_resetb, a_ready, a_valid}); end
    vectors++; if (a_gain !== 6'd0) begin errors++; $display("FAIL rst_a_gain: got %0d expected 0", a_gain); end
    vectors++; if (a_count !== 16'd0) begin errors++; $display("FAIL rst_a_count: got %0d expected 0", a_count); end
    vectors++; if ({b_resetbvco, b_resetb, b_ready, b_valid, b_gain, b_count} !== 15'b0) begin errors++; $display("FAIL rst_b_all: got %h expected 0", {b_resetbvco, b_resetb, b_ready, b_valid, b_gain, b_count}); end
    rst_n = 1'b1;
    cyc(10);
    vectors++; if ({a_resetbvco, a_ready, a_resetb} !== 4'b0) begin errors++; $display("FAIL load_idle: got %b expected 0000", {a_resetbvco, a_ready, a_resetb}); end
  endtask

  // Sends six bits (bits[0] first) and times the power-up sequence from the
  // cycle the last gain bit lands.
  task automatic test_sequence(input string tag, input logic [5:0] bits, input logic [5:0] exp_gain);
    int g, v, a, r;
    for (int i = 0; i < 5; i++) send_bit(bits[i]);
    sdin = bits[5];
    #40;
    sclk = 1'b1;
    g = -1; v = -1; a = -1; r = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge i_clk);
      #1;
      if (k == 5) sclk = 1'b0;
      if (g < 0 && a_gain === exp_gain) g = k;
      if (v < 0 && a_resetbvco === 1'b1) v = k;
      if (a < 0 && a_resetb === 2'b11) a = k;
      if (r < 0 && a_ready === 1'b1) r = k;
    end
    vectors++; if (g < 0) begin errors++; $display("FAIL %s_gain_seen: got none expected %b", tag, exp_gain); end
    vectors++; if (a_gain !== exp_gain) begin errors++; $display("FAIL %s_gain_a: got %b expected %b", tag, a_gain, exp_gain); end
    vectors++; if (b_gain !== exp_gain) begin errors++; $display("FAIL %s_gain_b: got %b expected %b", tag, b_gain, exp_gain); end
    vectors++; if (v - g !== 2) begin errors++; $display("FAIL %s_t_vco: got %0d expected 2", tag, v - g); end
    vectors++; if (a - g !== 12) begin errors++; $display("FAIL %s_t_amp: got %0d expected 12", tag, a - g); end
    vectors++; if (r - g !== 22) begin errors++; $display("FAIL %s_t_rdy: got %0d expected 22", tag, r - g); end
    vectors++; if ({b_resetbvco, b_resetb, b_ready} !== 4'b1111) begin errors++; $display("FAIL %s_b_up: got %b expected 1111", tag, {b_resetbvco, b_resetb, b_ready}); end
    vectors++; if (a_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_early: got %b expected 0", tag, a_valid); end
  endtask

  task automatic test_post_load_sclk(input logic [5:0] exp_gain);
    for (int i = 0; i < 6; i++) send_bit(~exp_gain[i]);
    cyc(5);
    vectors++; if (a_gain !== exp_gain) begin errors++; $display("FAIL post_gain_a: got %b expected %b", a_gain, exp_gain); end
    vectors++; if (b_gain !== exp_gain) begin errors++; $display("FAIL post_gain_b: got %b expected %b", b_gain, exp_gain); end
    vectors++; if ({a_resetbvco, a_resetb, a_ready} !== 4'b1111) begin errors++; $display("FAIL post_hold: got %b expected 1111", {a_resetbvco, a_resetb, a_ready}); end
  endtask

  task automatic test_measure;
    int n, spacing;
    n = 0;
    while (a_valid !== 1'b1 && n < 250) begin cyc(1); n++; end
    vectors++; if (a_valid !== 1'b1) begin errors++; $display("FAIL meas_first_valid: got timeout expected pulse"); end
    vectors++; if (a_count < 16'd19 || a_count > 16'd21) begin errors++; $display("FAIL meas_count1: got %0d expected 20", a_count); end
    vectors++; if (b_valid !== 1'b1) begin errors++; $display("FAIL meas_b_valid: got %b expected 1", b_valid); end
    vectors++; if (b_count !== 4'd15) begin errors++; $display("FAIL meas_sat: got %0d expected 15", b_count); end
    cyc(1);
    vectors++; if (a_valid !== 1'b0) begin errors++; $display("FAIL meas_pulse_width: got %b expected 0", a_valid); end
    spacing = 1;
    while (a_valid !== 1'b1 && spacing < 250) begin cyc(1); spacing++; end
    vectors++; if (spacing !== 100) begin errors++; $display("FAIL meas_period: got %0d expected 100", spacing); end
    vectors++; if (a_count < 16'd19 || a_count > 16'd21) begin errors++; $display("FAIL meas_count2: got %0d expected 20", a_count); end
    vectors++; if (b_count !== 4'd15) begin errors++; $display("FAIL meas_sat2: got %0d expected 15", b_count); end
  endtask

  task automatic test_reset_midload;
    cyc(37);
    rst_n = 1'b0;
    cyc(2);
    vectors++; if ({a_resetbvco, a_resetb, a_ready, a_valid} !== 5'b0) begin errors++; $display("FAIL abort_ctrl: got %b expected 00000", {a_resetbvco, a_resetb, a_ready, a_valid}); end
    vectors++; if (a_count !== 16'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", a_count); end
    rst_n = 1'b1;
    cyc(3);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    cyc(3);
    vectors++; if (a_gain !== 6'b000111) begin errors++; $display("FAIL partial_gain: got %b expected 000111", a_gain); end
    rst_n = 1'b0;
    cyc(2);
    vectors++; if (a_gain !== 6'd0) begin errors++; $display("FAIL partial_clear: got %b expected 000000", a_gain); end
    rst_n = 1'b1;
    cyc(3);
    test_sequence("reload", 6'b101110, 6'b101110);
  endtask

  initial begin
    test_reset();
    test_sequence("load", 6'b110101, 6'b110101);
    test_post_load_sclk(6'b110101);
    test_measure();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/backend_seq.md
BACKEND_SEQ -- requirements
Module: backend_seq

Interface
REQ-001 Parameter N_CH, default 2: number of amplifier channels, 1..8.
REQ-002 Parameter GAIN_W, default 3: gain bits per channel, 1..8.
REQ-003 Parameter T_VCO, default 2: i_clk cycles from load-complete to VCO reset release.
REQ-004 Parameter T_AMP, default 10: i_clk cycles from VCO release to amplifier reset release.
REQ-005 Parameter T_RDY, default 10: i_clk cycles from amplifier release to o_ready.
REQ-006 Parameter WIN, default 10000: measurement window length in i_clk cycles, at least 2.
REQ-007 Parameter FREQ_W, default 16: width of the VCO edge count.
REQ-008 Port i_clk, input, 1 bit: the only clock; all flops are on its rising edge.
REQ-009 Port i_resetbAll, input, 1 bit: asynchronous, active-low reset.
REQ-010 Port i_sclk, input, 1 bit: serial configuration clock, asynchronous to i_clk.
REQ-011 Port i_sdin, input, 1 bit: serial configuration data, sampled on rising i_sclk edges.
REQ-012 Port i_vco_clk, input, 1 bit: VCO output, asynchronous to i_clk, frequency below f(i_clk)/4.
REQ-013 Port o_resetbvco, output, 1 bit: VCO reset, active-low.
REQ-014 Port o_resetb, output, N_CH bits: per-channel amplifier resets, active-low.
REQ-015 Port o_gain, output, N_CH*GAIN_W bits: channel c gain occupies bits [c*GAIN_W +: GAIN_W].
REQ-016 Port o_ready, output, 1 bit: power-up sequence complete.
REQ-017 Port o_vco_count, output, FREQ_W bits: VCO rising edges counted in the last window.
REQ-018 Port o_vco_valid, output, 1 bit: one-cycle pulse when o_vco_count updates.

Function
REQ-019 i_sclk, i_sdin and i_vco_clk SHALL each pass through a 2-flop synchronizer; rising edges SHALL be detected on the synchronized values.
REQ-020 FSM states SHALL be LOAD, WAIT_VCO, WAIT_AMP, WAIT_RDY and RUN; LOAD is entered on reset release.
REQ-021 In LOAD, each detected sclk rise SHALL write the synchronized sdin (delayed by the same number of stages) to the next gain bit: channel 0 first, LSB first within each channel.
REQ-022 After N_CH*GAIN_W bits the FSM SHALL go to WAIT_VCO; sclk edges in any other state SHALL be ignored.
REQ-023 o_resetbvco SHALL rise exactly T_VCO cycles after entry to WAIT_VCO, at the same time as entry to WAIT_AMP.
REQ-024 All o_resetb bits SHALL rise together exactly T_AMP cycles after entry to WAIT_AMP, at the same time as entry to WAIT_RDY.
REQ-025 o_ready SHALL rise exactly T_RDY cycles after entry to WAIT_RDY, at the same time as entry to RUN.
REQ-026 RUN is terminal: outputs SHALL hold until reset.
REQ-027 In RUN, measurement SHALL repeat back-to-back: a window counter runs from 0 to WIN-1, and vco edges are counted.
REQ-028 On the last cycle of a window, o_vco_count SHALL load the count plus any edge detected in that cycle, o_vco_valid SHALL pulse, and the count SHALL restart at 0.
REQ-029 The edge count SHALL saturate at 2^FREQ_W-1 and SHALL NOT wrap.
REQ-030 Gain bits SHALL NOT change after LOAD exits.

Reset
REQ-031 While i_resetbAll is low, all outputs SHALL be 0, all counters and synchronizers SHALL be cleared, and the state SHALL be LOAD.
REQ-032 Reset asserted mid-operation SHALL abort immediately; partial gain loads and partial windows SHALL be discarded.

Structure
REQ-033 Package backend_seq_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-034 One sub-module, sync_edge, SHALL provide the 2-flop synchronizer with a registered rising-edge pulse; it is instantiated three times.

Verification
REQ-035 N_CH=2, GAIN_W=3, sdin bits 1,0,1,0,1,1 -> channel 0 gain = 5, channel 1 gain = 6, o_gain = 6'b110101.
REQ-036 Default timing -> o_resetbvco rises 2 cycles, o_resetb = 2'b11 rises 12 cycles, and o_ready rises 22 cycles after the 6th detected sclk edge.
REQ-037 WIN=100, i_vco_clk = i_clk/5 -> o_vco_valid every 100 cycles with o_vco_count = 20 (±1).
REQ-038 FREQ_W=4, WIN=100, i_vco_clk = i_clk/5 -> o_vco_count = 15 (saturated).
REQ-039 Reset asserted after 3 bits loaded, then released and 6 new bits sent -> the gain reflects only the new bits, and the sequence timing is as in REQ-036.
REQ-040 sclk edges sent after LOAD completes -> o_gain unchanged.
